mk_ehr_file: RTL and testbench

MK_EHR_FILE -- requirements
Module: mkEHRFile

---
 rtl/mk_ehr_file.sv | 121 ++++++++++++
 tb/tb_mk_ehr_file.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mk_ehr_file.sv
// mk_ehr_file: multi-port ordered-bypass register file (EHR style) with an
// automatic clear sequence after reset.
// Optional feature macro: EHRFILE_CONFLICT_CNT_EN enables the saturating
// same-address write-collision counter; without it conflict_cnt is tied to 0.
module mk_ehr_file #(
  parameter int unsigned       SIZE  = 4,
  parameter int unsigned       WIDTH = 32,
  parameter int unsigned       PORTS = 3,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  output logic                     RDY,
  input  logic [PORTS*SIZE-1:0]    r_addr,
  output logic [PORTS*WIDTH-1:0]   r_data,
  input  logic [PORTS-1:0]         EN_w,
  input  logic [PORTS*SIZE-1:0]    w_addr,
  input  logic [PORTS*WIDTH-1:0]   w_data,
  output logic [15:0]              conflict_cnt
);

  localparam int unsigned DEPTH = 2 ** SIZE;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd;

  // Control state register; RST_N high restarts the clear sequence.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk ptr across every entry, go READY after the last one.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + SIZE'(1);
      if (ptr_q == SIZE'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  assign RDY = (state_q == READY);

  // Storage update: clear writes in CLEAR, ordered port writes in READY
  // (later ports override earlier ones on the same entry).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      if (state_q == CLEAR) begin
        mem[ptr_q] <= INIT;
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          if (EN_w[p]) begin
            mem[w_addr[p*SIZE +: SIZE]] <= w_data[p*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Ordered read: port i sees the highest lower-indexed write to its address.
  always_comb begin
    r_data = '0;
    rd     = '0;
    for (int i = 0; i < PORTS; i++) begin
      rd = mem[r_addr[i*SIZE +: SIZE]];
      for (int j = 0; j < i; j++) begin
        if (EN_w[j] && (w_addr[j*SIZE +: SIZE] == r_addr[i*SIZE +: SIZE])) begin
          rd = w_data[j*WIDTH +: WIDTH];
        end
      end
      if (RDY) begin
        r_data[i*WIDTH +: WIDTH] = rd;
      end
    end
  end

`ifdef EHRFILE_CONFLICT_CNT_EN
  logic              collide_c;
  logic [CNT_W-1:0]  cnt_q;

  // Any pair of enabled write ports sharing an address; several pairs count once.
  always_comb begin
    collide_c = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = i + 1; j < PORTS; j++) begin
        if (EN_w[i] && EN_w[j] &&
            (w_addr[i*SIZE +: SIZE] == w_addr[j*SIZE +: SIZE])) begin
          collide_c = 1'b1;
        end
      end
    end
  end

  // Saturating collision counter, only active in READY.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      cnt_q <= '0;
    end else if ((state_q == READY) && collide_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mk_ehr_file.sv
// Self-checking bench for mk_ehr_file at default parameters.
// Define EHRFILE_CONFLICT_CNT_EN to also exercise the collision counter.
module tb_mk_ehr_file;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned PORTS = 3;

  logic                    CLK;
  logic                    RST_N;
  logic                    RDY;
  logic [PORTS*SIZE-1:0]   r_addr;
  logic [PORTS*WIDTH-1:0]  r_data;
  logic [PORTS-1:0]        EN_w;
  logic [PORTS*SIZE-1:0]   w_addr;
  logic [PORTS*WIDTH-1:0]  w_data;
  logic [15:0]             conflict_cnt;

  int checks;
  int failures;
  int exp_cnt;

  mk_ehr_file #(.SIZE(SIZE), .WIDTH(WIDTH), .PORTS(PORTS), .INIT('0)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .RDY(RDY),
    .r_addr(r_addr),
    .r_data(r_data),
    .EN_w(EN_w),
    .w_addr(w_addr),
    .w_data(w_data),
    .conflict_cnt(conflict_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and move away from the active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One cycle of reset, then release; returns in the window before clear edge 1.
  task automatic pulse_reset();
    EN_w  = '0;
    RST_N = 1'b1;
    step();
    RST_N = 1'b0;
  endtask

  task automatic test_reset();
    EN_w   = '0;
    w_addr = '0;
    w_data = '0;
    r_addr = {4'd9, 4'd4, 4'd1};
    RST_N  = 1'b1;
    step();
    checks++;
    if (RDY !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=0", RDY);
    end
    checks++;
    if (r_data !== '0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", r_data);
    end
    checks++;
    if (conflict_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%h exp=0", conflict_cnt);
    end
    RST_N = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (RDY !== 1'b0) begin
        failures++;
        $display("FAIL clear_rdy_low cycle=%0d got=%b exp=0", k + 1, RDY);
      end
      step();
    end
    checks++;
    if (RDY !== 1'b1) begin
      failures++;
      $display("FAIL clear_rdy_rise got=%b exp=1", RDY);
    end
    for (int a = 0; a < 16; a++) begin
      r_addr = {3{4'(a)}};
      #1;
      checks++;
      if (r_data !== '0) begin
        failures++;
        $display("FAIL cleared_entry addr=%0d got=%h exp=0", a, r_data);
      end
    end
    exp_cnt = 0;
  endtask

  task automatic test_bypass();
    EN_w   = 3'b001;
    w_addr = {4'd0, 4'd0, 4'd5};
    w_data = {32'h0, 32'h0, 32'hA};
    r_addr = {4'd5, 4'd5, 4'd5};
    #1;
    checks++;
    if (r_data[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL bypass_p0 got=%h exp=0", r_data[31:0]);
    end
    checks++;
    if (r_data[63:32] !== 32'hA) begin
      failures++;
      $display("FAIL bypass_p1 got=%h exp=a", r_data[63:32]);
    end
    checks++;
    if (r_data[95:64] !== 32'hA) begin
      failures++;
      $display("FAIL bypass_p2 got=%h exp=a", r_data[95:64]);
    end
    step();
    EN_w = '0;
    #1;
    checks++;
    if (r_data[31:0] !== 32'hA) begin
      failures++;
      $display("FAIL bypass_next_p0 got=%h exp=a", r_data[31:0]);
    end
  endtask

  task automatic test_collision();
    // Ports 0 and 2 both write addr 3.
    EN_w   = 3'b101;
    w_addr = {4'd3, 4'd0, 4'd3};
    w_data = {32'h2, 32'h0, 32'h1};
    r_addr = {4'd3, 4'd3, 4'd3};
    #1;
    checks++;
    if (r_data !== {32'h1, 32'h1, 32'h0}) begin
      failures++;
      $display("FAIL coll_read got=%h exp=%h", r_data, {32'h1, 32'h1, 32'h0});
    end
    step();
`ifdef EHRFILE_CONFLICT_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    EN_w = '0;
    #1;
    checks++;
    if (r_data[31:0] !== 32'h2) begin
      failures++;
      $display("FAIL coll_winner got=%h exp=2", r_data[31:0]);
    end
    checks++;
    if (conflict_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL coll_cnt1 got=%h exp=%h", conflict_cnt, 16'(exp_cnt));
    end
    // Ports 0 and 1 both write addr 7; port 2 sees port 1's data.
    EN_w   = 3'b011;
    w_addr = {4'd0, 4'd7, 4'd7};
    w_data = {32'h0, 32'h22, 32'h11};
    r_addr = {4'd7, 4'd7, 4'd7};
    #1;
    checks++;
    if (r_data !== {32'h22, 32'h11, 32'h0}) begin
      failures++;
      $display("FAIL coll2_read got=%h exp=%h", r_data, {32'h22, 32'h11, 32'h0});
    end
    step();
`ifdef EHRFILE_CONFLICT_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    // Non-colliding writes on ports 1 and 2.
    EN_w   = 3'b110;
    w_addr = {4'd9, 4'd8, 4'd0};
    w_data = {32'h44, 32'h33, 32'h0};
    r_addr = {4'd0, 4'd0, 4'd7};
    #1;
    checks++;
    if (r_data[31:0] !== 32'h22) begin
      failures++;
      $display("FAIL coll2_winner got=%h exp=22", r_data[31:0]);
    end
    step();
    EN_w   = '0;
    r_addr = {4'd0, 4'd9, 4'd8};
    #1;
    checks++;
    if (r_data[63:0] !== {32'h44, 32'h33}) begin
      failures++;
      $display("FAIL nocoll_data got=%h exp=%h", r_data[63:0], {32'h44, 32'h33});
    end
    checks++;
    if (conflict_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL coll_cnt2 got=%h exp=%h", conflict_cnt, 16'(exp_cnt));
    end
  endtask

  task automatic test_reset_mid_clear();
    pulse_reset();
    repeat (7) step();
    RST_N = 1'b1;
    step();
    exp_cnt = 0;
    checks++;
    if (conflict_cnt !== 16'h0) begin
      failures++;
      $display("FAIL midclr_cnt got=%h exp=0", conflict_cnt);
    end
    RST_N = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (RDY !== 1'b0) begin
        failures++;
        $display("FAIL midclr_rdy_low cycle=%0d got=%b exp=0", k + 1, RDY);
      end
      step();
    end
    checks++;
    if (RDY !== 1'b1) begin
      failures++;
      $display("FAIL midclr_rdy_rise got=%b exp=1", RDY);
    end
  endtask

  task automatic test_write_during_clear();
    EN_w   = 3'b001;
    w_addr = {4'd0, 4'd0, 4'd15};
    w_data = {32'h0, 32'h0, 32'h55};
    step();
    EN_w   = '0;
    r_addr = {3{4'd15}};
    #1;
    checks++;
    if (r_data[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL wdc_preload got=%h exp=55", r_data[31:0]);
    end
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        EN_w   = 3'b010;
        w_addr = {4'd0, 4'd15, 4'd0};
        w_data = {32'h0, 32'hFF, 32'h0};
      end
      #1;
      checks++;
      if (r_data !== '0) begin
        failures++;
        $display("FAIL wdc_read_zero cycle=%0d got=%h exp=0", k + 1, r_data);
      end
      step();
      EN_w = '0;
    end
    checks++;
    if (RDY !== 1'b1) begin
      failures++;
      $display("FAIL wdc_rdy got=%b exp=1", RDY);
    end
    #1;
    checks++;
    if (r_data !== '0) begin
      failures++;
      $display("FAIL wdc_entry15 got=%h exp=0", r_data);
    end
  endtask

`ifdef EHRFILE_CONFLICT_CNT_EN
  task automatic test_counter();
    // Three ports on one address is one colliding cycle.
    EN_w   = 3'b111;
    w_addr = {3{4'd2}};
    w_data = {32'h3, 32'h2, 32'h1};
    step();
    EN_w = '0;
    #1;
    checks++;
    if (conflict_cnt !== 16'h1) begin
      failures++;
      $display("FAIL cnt_multi_pair got=%h exp=1", conflict_cnt);
    end
    EN_w   = 3'b011;
    w_addr = {4'd0, 4'd6, 4'd6};
    repeat (65540) step();
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_saturate got=%h exp=ffff", conflict_cnt);
    end
    step();
    EN_w = '0;
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_hold got=%h exp=ffff", conflict_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    RST_N    = 1'b1;
    EN_w     = '0;
    r_addr   = '0;
    w_addr   = '0;
    w_data   = '0;
    test_reset();
    test_bypass();
    test_collision();
    test_reset_mid_clear();
    test_write_during_clear();
`ifdef EHRFILE_CONFLICT_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
